pipe_ctrl: RTL

Registered control unit for the 5-stage MIPS pipeline. It decodes the ID-stage opcode and carries the control bundle and destination register through ID/EX, EX/MEM and MEM/WB. It detects load-use hazards and stalls for a parametrised number of cycles. It resolves beq/bne/j in ID, driving PC select and IF/ID flush. It sits beside the datapath, between the IF/ID register and the stage registers.

---
 rtl/mips_pkg.sv | 52 +++++
 rtl/pipe_ctrl_if.sv | 44 ++++
 rtl/ctrl_decode.sv | 47 ++++
 rtl/pipe_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline control definitions: opcodes, ALU codes, PC selects and control bundles.
package mips_pkg;

    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned CTRL_ALU_W = 3;
    localparam int unsigned PC_SEL_W   = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;

    localparam logic [CTRL_ALU_W-1:0] ALU_MEM   = 3'b000;
    localparam logic [CTRL_ALU_W-1:0] ALU_BR    = 3'b001;
    localparam logic [CTRL_ALU_W-1:0] ALU_FUNCT = 3'b010;
    localparam logic [CTRL_ALU_W-1:0] ALU_ADDI  = 3'b011;
    localparam logic [CTRL_ALU_W-1:0] ALU_SLTI  = 3'b100;

    localparam logic [PC_SEL_W-1:0] PC_SEQ = 2'd0;
    localparam logic [PC_SEL_W-1:0] PC_BR  = 2'd1;
    localparam logic [PC_SEL_W-1:0] PC_JMP = 2'd2;

    // Full control bundle produced in ID and held in ID/EX.
    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_dst;
        logic                  alu_src;
        logic [CTRL_ALU_W-1:0] alu_op;
    } ctrl_t;

    // Controls still needed once the instruction has left EX.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    // Controls still needed once the instruction has left MEM.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// ID-stage inputs and per-stage control outputs of the pipeline control unit.
interface pipe_ctrl_if
    import mips_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned ALU_OP_W = 3
);
    logic [OPCODE_W-1:0] opCode;
    logic [REG_AW-1:0]   id_rs;
    logic [REG_AW-1:0]   id_rt;
    logic [REG_AW-1:0]   id_rd;
    logic                id_eq;

    logic                ldPC;
    logic                ldIFID;
    logic                flushIFID;
    logic [PC_SEL_W-1:0] pcSel;
    logic                ex_Reg_Dst;
    logic                ex_ALU_Src;
    logic [ALU_OP_W-1:0] ex_ALU_Op;
    logic                mem_Mem_Read;
    logic                mem_Mem_Write;
    logic                wb_Reg_Write;
    logic                wb_Mem_To_Reg;
    logic [REG_AW-1:0]   ex_dst;
    logic [REG_AW-1:0]   mem_dst;
    logic [REG_AW-1:0]   wb_dst;

    modport master (
        output opCode, id_rs, id_rt, id_rd, id_eq,
        input  ldPC, ldIFID, flushIFID, pcSel,
        input  ex_Reg_Dst, ex_ALU_Src, ex_ALU_Op,
        input  mem_Mem_Read, mem_Mem_Write, wb_Reg_Write, wb_Mem_To_Reg,
        input  ex_dst, mem_dst, wb_dst
    );

    modport slave (
        input  opCode, id_rs, id_rt, id_rd, id_eq,
        output ldPC, ldIFID, flushIFID, pcSel,
        output ex_Reg_Dst, ex_ALU_Src, ex_ALU_Op,
        output mem_Mem_Read, mem_Mem_Write, wb_Reg_Write, wb_Mem_To_Reg,
        output ex_dst, mem_dst, wb_dst
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder producing the ID-stage control bundle.
module ctrl_decode
    import mips_pkg::*;
(
    input  logic [OPCODE_W-1:0] op_code,
    output ctrl_t               ctrl_c
);

    // Unknown opcodes fall through to an all-zero bundle, i.e. a NOP.
    always_comb begin
        ctrl_c = '0;
        case (op_code)
            OP_RTYPE: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = 1'b1;
                ctrl_c.alu_op    = ALU_FUNCT;
            end
            OP_LW: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_read   = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                ctrl_c.alu_src    = 1'b1;
                ctrl_c.alu_op     = ALU_MEM;
            end
            OP_SW: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.alu_op    = ALU_MEM;
            end
            OP_BEQ, OP_BNE: begin
                ctrl_c.alu_op = ALU_BR;
            end
            OP_ADDI: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.alu_op    = ALU_ADDI;
            end
            OP_SLTI: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.alu_op    = ALU_SLTI;
            end
            default: ctrl_c = '0;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: ID decode, stage control registers, load-use stall and ID-stage branch/jump resolve.
module pipe_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned ALU_OP_W     = 3,
    parameter int unsigned STALL_CYCLES = 1
)(
    input  logic     clk,
    input  logic     rst,
    pipe_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = 2;

    ctrl_t             id_ctrl_c;
    logic [REG_AW-1:0] id_dst_c;

    ctrl_t             ex_ctrl;
    logic [REG_AW-1:0] ex_dst;
    mem_ctrl_t         mem_ctrl;
    logic [REG_AW-1:0] mem_dst;
    wb_ctrl_t          wb_ctrl;
    logic [REG_AW-1:0] wb_dst;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              hazard_c;
    logic              stall_c;
    logic              br_taken_c;
    logic              jmp_c;

    ctrl_decode u_decode (
        .op_code (bus.opCode),
        .ctrl_c  (id_ctrl_c)
    );

    // Destination only meaningful for writers; non-writers carry $0 so they never match a hazard.
    always_comb begin
        id_dst_c = '0;
        if (id_ctrl_c.reg_write) begin
            id_dst_c = id_ctrl_c.reg_dst ? bus.id_rd : bus.id_rt;
        end
    end

    // Stall counter state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Hazard detection and stall counter next state; new hazards are only considered when idle.
    always_comb begin
        hazard_c = 1'b0;
        stall_c  = 1'b0;
        cnt_nxt  = cnt;
        hazard_c = ex_ctrl.mem_read && (ex_dst != '0) &&
                   ((ex_dst == bus.id_rs) || (ex_dst == bus.id_rt));
        if (cnt != '0) begin
            stall_c = 1'b1;
            cnt_nxt = cnt - CNT_W'(1);
        end else if (hazard_c) begin
            stall_c = 1'b1;
            cnt_nxt = CNT_W'(STALL_CYCLES - 1);
        end
    end

    // Control-transfer decisions resolved in ID.
    always_comb begin
        br_taken_c = 1'b0;
        jmp_c      = 1'b0;
        br_taken_c = ((bus.opCode == OP_BEQ) && bus.id_eq) ||
                     ((bus.opCode == OP_BNE) && !bus.id_eq);
        jmp_c      = (bus.opCode == OP_J);
    end

    // Fetch-side outputs; stall wins over transfer, and everything reads zero while in reset.
    always_comb begin
        bus.ldPC      = 1'b0;
        bus.ldIFID    = 1'b0;
        bus.flushIFID = 1'b0;
        bus.pcSel     = PC_SEQ;
        if (rst && !stall_c) begin
            bus.ldPC   = 1'b1;
            bus.ldIFID = 1'b1;
            if (jmp_c) begin
                bus.pcSel     = PC_JMP;
                bus.flushIFID = 1'b1;
            end else if (br_taken_c) begin
                bus.pcSel     = PC_BR;
                bus.flushIFID = 1'b1;
            end
        end
    end

    // ID/EX, EX/MEM and MEM/WB control registers; a stall inserts a bubble into ID/EX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_ctrl  <= '0;
            ex_dst   <= '0;
            mem_ctrl <= '0;
            mem_dst  <= '0;
            wb_ctrl  <= '0;
            wb_dst   <= '0;
        end else begin
            ex_ctrl  <= stall_c ? ctrl_t'('0) : id_ctrl_c;
            ex_dst   <= stall_c ? '0 : id_dst_c;
            mem_ctrl <= '{reg_write:  ex_ctrl.reg_write,
                          mem_to_reg: ex_ctrl.mem_to_reg,
                          mem_read:   ex_ctrl.mem_read,
                          mem_write:  ex_ctrl.mem_write};
            mem_dst  <= ex_dst;
            wb_ctrl  <= '{reg_write:  mem_ctrl.reg_write,
                          mem_to_reg: mem_ctrl.mem_to_reg};
            wb_dst   <= mem_dst;
        end
    end

    assign bus.ex_Reg_Dst    = ex_ctrl.reg_dst;
    assign bus.ex_ALU_Src    = ex_ctrl.alu_src;
    assign bus.ex_ALU_Op     = ALU_OP_W'(ex_ctrl.alu_op);
    assign bus.mem_Mem_Read  = mem_ctrl.mem_read;
    assign bus.mem_Mem_Write = mem_ctrl.mem_write;
    assign bus.wb_Reg_Write  = wb_ctrl.reg_write;
    assign bus.wb_Mem_To_Reg = wb_ctrl.mem_to_reg;
    assign bus.ex_dst        = ex_dst;
    assign bus.mem_dst       = mem_dst;
    assign bus.wb_dst        = wb_dst;

endmodule
